fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter sequencer for the fetch stage: generates the 16-bit word address into the instruction memory and drives its `stall` and `kill` inputs. It also tracks whether the instruction currently latched by the memory is on the correct path. Redirects come from decode/execute as jump/branch, CALL, or RET. CALL/RET targets are resolved through an internal return-address stack. It sits between the hazard/branch logic and the instruction memory.

## Interface
- `RESET_PC`, 16'h0000, address fetched first after reset
- `RAS_DEPTH`, 4, return-stack entries (power of two, 2..16)

Ports:
- `clk` in 1 — rising-edge clock
- `reset` in 1 — asynchronous, active-low reset
- `stall_in` in 1 — hazard unit requests fetch hold
- `redir_valid` in 1 — redirect request this cycle
- `redir_kind` in 2 — 00 jump/branch, 01 CALL, 10 RET, 11 reserved (treated as 00)
- `redir_target` in 16 — target for jump/branch/CALL; fallback for RET
- `redir_link` in 16 — return address pushed on CALL (CALL pc + 1)
- `pc` out 16 — address to instruction memory (registered)
- `imem_stall` out 1 — to memory `stall`
- `imem_kill` out 1 — to memory `kill`; high in the cycle a redirect is accepted
- `fetch_valid` out 1 — memory's instruction output is correct-path
- `ras_overflow` out 1 — sticky: CALL pushed onto full stack
- `ras_underflow` out 1 — sticky: RET on empty stack

## Operation
- Priority per edge: reset > redirect > stall > sequential.
- Sequential: `pc <= pc + 1`, 16-bit wrap (16'hFFFF -> 16'h0000); `fetch_valid <= 1`.
- Stall (no redirect): `pc`, `fetch_valid`, and stack hold. `imem_stall = stall_in & ~redir_valid`.
- Redirect (overrides stall):
  - `pc <= resolved target`.
  - `fetch_valid <= 0`, because the memory latches the old-path word on this edge.
  - `imem_kill = redir_valid` (combinational). `imem_stall = 0`.
- Jump/branch: target = `redir_target`.
- CALL: target = `redir_target`; push `redir_link`.
  - If the stack is full, the oldest entry is overwritten (circular) and `ras_overflow` is set.
  - Count saturates at `RAS_DEPTH`.
- RET: if not empty, target = top of stack; pop. `redir_target` is ignored.
  - If empty, target = `redir_target`, `ras_underflow` is set, and the count stays 0.
- Sticky flags clear only on reset.
- Stack pointer and count widths are log2(`RAS_DEPTH`) and log2(`RAS_DEPTH`)+1.

## Timing
- Reset values, applied asynchronously on `reset` = 0:
  - `pc = RESET_PC`
  - `fetch_valid = 0`
  - `ras_overflow = 0`, `ras_underflow = 0`
  - stack count = 0, pointer = 0
  - `imem_stall`/`imem_kill` follow inputs (combinational)
- Reset released mid-operation discards the whole stack. The first edge after deassertion latches mem[`RESET_PC`] and advances `pc`; `fetch_valid` goes 1 on that edge.
- The memory read is registered: the word at `pc` in cycle t is visible in cycle t+1.
- `fetch_valid` in cycle t+1 qualifies that word.
- Redirect penalty: exactly one invalid fetch slot. Redirect sampled at edge t gives `fetch_valid = 0` in t+1 and mem[target] with `fetch_valid = 1` in t+2, absent stall.
- Back-to-back redirects: each is honoured; `fetch_valid` stays 0 until one non-redirect edge occurs.
- Stall held for N cycles holds `pc` for N edges; the memory output is unchanged.

## Configuration
- `FETCH_RAS_EN` defined: return stack of `RAS_DEPTH` entries as above.
- `FETCH_RAS_EN` undefined:
  - No stack storage.
  - CALL behaves as a jump, and the link is discarded.
  - RET uses `redir_target` as its target.
  - `ras_overflow`/`ras_underflow` are tied 0.
  - `RAS_DEPTH` is ignored.

## Test plan
- Reset to `RESET_PC` = 0, then 4 free-running cycles -> `pc` 0,1,2,3,4; `fetch_valid` 0 then 1 from the first edge.
- Stall 3 cycles at `pc` = 5 -> `pc` holds 5, `imem_stall` = 1; resume -> `pc` = 6 next edge.
- Jump to 16'h000A while stalled -> `imem_kill` = 1, `imem_stall` = 0, `pc` = 10, `fetch_valid` 0 for one cycle then 1, `pc` = 11.
- CALL target 16'h00A link 16'h0006, then RET with `redir_target` = 0 -> `pc` = 6, stack empty, no flags.
- 5 CALLs (links 1..5) with `RAS_DEPTH` = 4, then 5 RETs (`redir_target` = 16'h0F00) -> returns 5,4,3,2; `ras_overflow` = 1; fifth RET -> `pc` = 16'h0F00, `ras_underflow` = 1.
- `pc` = 16'hFFFF, no stall -> next `pc` = 16'h0000; assert `reset` = 0 asynchronously mid-cycle -> `pc` = `RESET_PC` immediately and flags = 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Program-counter sequencer for the fetch stage. It produces the word address
// into a registered instruction memory, drives that memory's stall and kill
// inputs, and tracks whether the word the memory currently presents is on the
// correct path. Redirects come from decode/execute as jump/branch, CALL or RET.
// CALL/RET targets resolve through an optional return-address stack.
//
// Build option: define FETCH_RAS_EN to include the return-address stack.
// Without it, CALL acts as a plain jump, RET uses redir_target, and the
// stack flags are tied low.
//
// Parameters:
//   RESET_PC   - first address fetched after reset
//   RAS_DEPTH  - return-stack entries (power of two, 2..16)
//
// Ports:
//   clk           in  rising-edge clock
//   reset         in  asynchronous active-low reset
//   stall_in      in  hazard unit requests fetch hold
//   redir_valid   in  redirect request this cycle
//   redir_kind    in  2'b00 jump/branch, 2'b01 CALL, 2'b10 RET, 2'b11 as jump
//   redir_target  in  target for jump/CALL, fallback for RET on empty stack
//   redir_link    in  return address pushed on CALL
//   pc            out registered address to instruction memory
//   imem_stall    out memory stall (hold requested and no redirect)
//   imem_kill     out memory kill (redirect accepted this cycle)
//   fetch_valid   out memory output word is on the correct path
//   ras_overflow  out sticky: CALL pushed onto a full stack
//   ras_underflow out sticky: RET on an empty stack
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [15:0] redir_target,
    input  logic [15:0] redir_link,
    output logic [15:0] pc,
    output logic        imem_stall,
    output logic        imem_kill,
    output logic        fetch_valid,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    logic [15:0] target;

    // A redirect always wins over a hold request from the hazard unit.
    assign imem_stall = stall_in & ~redir_valid;
    assign imem_kill  = redir_valid;

`ifdef FETCH_RAS_EN
    localparam logic [1:0] KIND_CALL = 2'b01;
    localparam logic [1:0] KIND_RET  = 2'b10;
    localparam int         PTR_W     = $clog2(RAS_DEPTH);
    localparam int         CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [15:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] sp;       // next free slot; also the oldest slot when full
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] top_idx;
    logic             is_call;
    logic             is_ret;
    logic             ras_empty;
    logic             ras_full;

    assign is_call   = redir_valid && (redir_kind == KIND_CALL);
    assign is_ret    = redir_valid && (redir_kind == KIND_RET);
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_FULL);
    assign top_idx   = sp - 1'b1;

    always_comb begin
        target = redir_target;
        if (is_ret && !ras_empty) begin
            target = ras_mem[top_idx];
        end
    end

    // Stack control. A push onto a full stack overwrites the oldest entry,
    // which is exactly the slot sp points at once the ring has wrapped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp            <= '0;
            cnt           <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (is_call) begin
            sp <= sp + 1'b1;
            if (ras_full) begin
                ras_overflow <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (is_ret) begin
            if (ras_empty) begin
                ras_underflow <= 1'b1;
            end else begin
                sp  <= top_idx;
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Stack storage carries no reset; a zero count makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (is_call) begin
            ras_mem[sp] <= redir_link;
        end
    end
`else
    logic unused_redir;

    assign target        = redir_target;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
    assign unused_redir  = ^{redir_kind, redir_link};
`endif

    // PC and path-validity register. The memory latches the old-path word on a
    // redirect edge, so validity drops for exactly that slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
        end else if (redir_valid) begin
            pc          <= target;
            fetch_valid <= 1'b0;
        end else if (!stall_in) begin
            pc          <= pc + 16'd1;
            fetch_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Directed testbench for fetch_sequencer with hand-computed expectations.
// Expectations for CALL/RET follow whether FETCH_RAS_EN is defined.
module tb_fetch_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redir_valid;
    logic [1:0]  redir_kind;
    logic [15:0] redir_target;
    logic [15:0] redir_link;
    logic [15:0] pc;
    logic        imem_stall;
    logic        imem_kill;
    logic        fetch_valid;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_vec = 0;
    int n_err = 0;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_in      (stall_in),
        .redir_valid   (redir_valid),
        .redir_kind    (redir_kind),
        .redir_target  (redir_target),
        .redir_link    (redir_link),
        .pc            (pc),
        .imem_stall    (imem_stall),
        .imem_kill     (imem_kill),
        .fetch_valid   (fetch_valid),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall_in = 1'b0; redir_valid = 1'b0;
        redir_kind = 2'b00; redir_target = 16'h0000; redir_link = 16'h0000;
        #2;
        n_vec++; if (pc !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
        n_vec++; if ({ras_overflow, ras_underflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {ras_overflow, ras_underflow}); end
        n_vec++; if ({imem_stall, imem_kill} !== 2'b00) begin n_err++; $display("FAIL reset_imem: got %b want 00", {imem_stall, imem_kill}); end
        #10;
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++; if (pc !== 16'(i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 16'(i)); end
            n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq_fv[%0d]: got %b want 1", i, fetch_valid); end
        end
        tick();
        n_vec++; if (pc !== 16'h0005) begin n_err++; $display("FAIL seq_pc5: got %h want 0005", pc); end
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        #1;
        n_vec++; if (imem_stall !== 1'b1) begin n_err++; $display("FAIL stall_out: got %b want 1", imem_stall); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc !== 16'h0005) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 0005", i, pc); end
            n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL stall_fv[%0d]: got %b want 1", i, fetch_valid); end
        end
        stall_in = 1'b0;
        tick();
        n_vec++; if (pc !== 16'h0006) begin n_err++; $display("FAIL resume_pc: got %h want 0006", pc); end
    endtask

    task automatic test_jump_stalled();
        stall_in = 1'b1; redir_valid = 1'b1; redir_kind = 2'b00; redir_target = 16'h000A;
        #1;
        n_vec++; if (imem_kill !== 1'b1) begin n_err++; $display("FAIL jump_kill: got %b want 1", imem_kill); end
        n_vec++; if (imem_stall !== 1'b0) begin n_err++; $display("FAIL jump_stall: got %b want 0", imem_stall); end
        tick();
        n_vec++; if (pc !== 16'h000A) begin n_err++; $display("FAIL jump_pc: got %h want 000a", pc); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL jump_fv0: got %b want 0", fetch_valid); end
        redir_valid = 1'b0; stall_in = 1'b0;
        #1;
        n_vec++; if (imem_kill !== 1'b0) begin n_err++; $display("FAIL jump_kill_off: got %b want 0", imem_kill); end
        tick();
        n_vec++; if (pc !== 16'h000B) begin n_err++; $display("FAIL jump_pc_next: got %h want 000b", pc); end
        n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL jump_fv1: got %b want 1", fetch_valid); end
    endtask

    task automatic test_call_ret();
        logic [15:0] exp_ret;
        exp_ret = RAS_EN ? 16'h0006 : 16'h0000;
        redir_valid = 1'b1; redir_kind = 2'b01; redir_target = 16'h000A; redir_link = 16'h0006;
        tick();
        n_vec++; if (pc !== 16'h000A) begin n_err++; $display("FAIL call_pc: got %h want 000a", pc); end
        redir_kind = 2'b10; redir_target = 16'h0000;
        tick();
        n_vec++; if (pc !== exp_ret) begin n_err++; $display("FAIL ret_pc: got %h want %h", pc, exp_ret); end
        n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL ret_fv: got %b want 0", fetch_valid); end
        redir_valid = 1'b0;
        tick();
        n_vec++; if (pc !== exp_ret + 16'd1) begin n_err++; $display("FAIL ret_pc_next: got %h want %h", pc, exp_ret + 16'd1); end
        n_vec++; if ({ras_overflow, ras_underflow} !== 2'b00) begin n_err++; $display("FAIL callret_flags: got %b want 00", {ras_overflow, ras_underflow}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pc;
        for (int i = 1; i <= 5; i++) begin
            redir_valid = 1'b1; redir_kind = 2'b01;
            redir_target = 16'h0100 + 16'(i); redir_link = 16'(i);
            tick();
            n_vec++; if (pc !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL b2b_call_pc[%0d]: got %h want %h", i, pc, 16'h0100 + 16'(i)); end
            n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL b2b_call_fv[%0d]: got %b want 0", i, fetch_valid); end
            if (i == 4) begin
                n_vec++; if (ras_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: got %b want 0", ras_overflow); end
            end
        end
        n_vec++; if (ras_overflow !== RAS_EN) begin n_err++; $display("FAIL ovf_set: got %b want %b", ras_overflow, RAS_EN); end
        for (int i = 0; i < 5; i++) begin
            redir_kind = 2'b10; redir_target = 16'h0F00;
            exp_pc = (RAS_EN && i < 4) ? 16'(5 - i) : 16'h0F00;
            tick();
            n_vec++; if (pc !== exp_pc) begin n_err++; $display("FAIL b2b_ret_pc[%0d]: got %h want %h", i, pc, exp_pc); end
            n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL b2b_ret_fv[%0d]: got %b want 0", i, fetch_valid); end
            if (i == 3) begin
                n_vec++; if (ras_underflow !== 1'b0) begin n_err++; $display("FAIL unf_early: got %b want 0", ras_underflow); end
            end
        end
        n_vec++; if (ras_underflow !== RAS_EN) begin n_err++; $display("FAIL unf_set: got %b want %b", ras_underflow, RAS_EN); end
        redir_valid = 1'b0;
        tick();
        n_vec++; if (pc !== 16'h0F01) begin n_err++; $display("FAIL b2b_pc_next: got %h want 0f01", pc); end
        n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL b2b_fv1: got %b want 1", fetch_valid); end
    endtask

    task automatic test_wrap_async_reset();
        redir_valid = 1'b1; redir_kind = 2'b01; redir_target = 16'hFFFF; redir_link = 16'h1234;
        tick();
        n_vec++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_setup: got %h want ffff", pc); end
        redir_valid = 1'b0;
        tick();
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", pc); end
        tick();
        n_vec++; if (pc !== 16'h0001) begin n_err++; $display("FAIL wrap_pc1: got %h want 0001", pc); end
        #3;
        reset = 1'b0; redir_valid = 1'b1; redir_kind = 2'b00; redir_target = 16'h0777;
        #1;
        n_vec++; if (pc !== RESET_PC) begin n_err++; $display("FAIL async_pc: got %h want %h", pc, RESET_PC); end
        n_vec++; if ({ras_overflow, ras_underflow, fetch_valid} !== 3'b000) begin n_err++; $display("FAIL async_flags: got %b want 000", {ras_overflow, ras_underflow, fetch_valid}); end
        n_vec++; if (imem_kill !== 1'b1) begin n_err++; $display("FAIL async_kill: got %b want 1", imem_kill); end
        tick();
        n_vec++; if (pc !== RESET_PC) begin n_err++; $display("FAIL held_pc: got %h want %h", pc, RESET_PC); end
        redir_valid = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        n_vec++; if (pc !== RESET_PC + 16'd1) begin n_err++; $display("FAIL post_reset_pc: got %h want %h", pc, RESET_PC + 16'd1); end
        n_vec++; if (fetch_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_fv: got %b want 1", fetch_valid); end
        // Stack must have been discarded: RET falls back to redir_target.
        redir_valid = 1'b1; redir_kind = 2'b10; redir_target = 16'h0F00;
        tick();
        n_vec++; if (pc !== 16'h0F00) begin n_err++; $display("FAIL discard_pc: got %h want 0f00", pc); end
        n_vec++; if (ras_underflow !== RAS_EN) begin n_err++; $display("FAIL discard_unf: got %b want %b", ras_underflow, RAS_EN); end
        redir_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_jump_stalled();
        test_call_ret();
        test_back_to_back();
        test_wrap_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
